// File: rtl/edge_detector_hyst_rnm_if.sv
// Port bundle for edge_detector_hyst_rnm. The master drives the analog levels and controls;
// the slave (the detector) returns the qualified levels, edge pulses and edge counts.
interface edge_detector_hyst_rnm_if #(
   parameter int N_CH  = 4,
   parameter int CNT_W = 8
);
   real                   a_i [N_CH];
   logic [N_CH-1:0]       ch_en_i;
   logic                  clr_i;
   logic [N_CH-1:0]       level_o;
   logic [N_CH-1:0]       rising_edge_o;
   logic [N_CH-1:0]       falling_edge_o;
   logic [N_CH*CNT_W-1:0] rise_cnt_o;
   logic [N_CH*CNT_W-1:0] fall_cnt_o;

   modport master (
      output a_i, ch_en_i, clr_i,
      input  level_o, rising_edge_o, falling_edge_o, rise_cnt_o, fall_cnt_o
   );

   modport slave (
      input  a_i, ch_en_i, clr_i,
      output level_o, rising_edge_o, falling_edge_o, rise_cnt_o, fall_cnt_o
   );
endinterface

// File: rtl/edge_detector_hyst_rnm.sv
// Multi-channel hysteresis comparator with debounce, one-cycle edge pulses and saturating
// edge counters; the counters exist only when EDGE_DETECTOR_HYST_CNT_EN is defined.
module edge_detector_hyst_rnm #(
   parameter int  N_CH    = 4,
   parameter real VTH_HI  = 0.7,
   parameter real VTH_LO  = 0.3,
   parameter int  DEB_CYC = 2,
   parameter int  CNT_W   = 8
) (
   input logic                      clk,
   input logic                      reset,
   edge_detector_hyst_rnm_if.slave  bus
);

   localparam int DEB_W = 8;

   logic [N_CH-1:0]  level_q, level_d;
   logic [N_CH-1:0]  rise_q, rise_d;
   logic [N_CH-1:0]  fall_q, fall_d;
   logic [N_CH-1:0]  cand;
   logic [DEB_W-1:0] deb_q [N_CH];
   logic [DEB_W-1:0] deb_d [N_CH];

   // Once high, a channel only drops at or below VTH_LO; once low it only rises at or above VTH_HI.
   always_comb begin
      level_d = level_q;
      rise_d  = '0;
      fall_d  = '0;
      cand    = '0;
      for (int k = 0; k < N_CH; k++) begin
         deb_d[k] = '0;
         cand[k]  = level_q[k] ? (bus.a_i[k] > VTH_LO) : (bus.a_i[k] >= VTH_HI);
         if (bus.ch_en_i[k] && (cand[k] != level_q[k])) begin
            if (deb_q[k] < DEB_W'(DEB_CYC)) begin
               deb_d[k] = deb_q[k] + DEB_W'(1);
            end else begin
               level_d[k] = cand[k];
               rise_d[k]  = cand[k];
               fall_d[k]  = ~cand[k];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= '0;
         rise_q  <= '0;
         fall_q  <= '0;
         for (int k = 0; k < N_CH; k++) begin
            deb_q[k] <= '0;
         end
      end else begin
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         deb_q   <= deb_d;
      end
   end

   assign bus.level_o        = level_q;
   assign bus.rising_edge_o  = rise_q;
   assign bus.falling_edge_o = fall_q;

`ifdef EDGE_DETECTOR_HYST_CNT_EN
   logic [N_CH*CNT_W-1:0] rcnt_q, rcnt_d;
   logic [N_CH*CNT_W-1:0] fcnt_q, fcnt_d;

   // Counts follow the pulse being generated this edge; a clear on that same edge wins.
   always_comb begin
      rcnt_d = rcnt_q;
      fcnt_d = fcnt_q;
      for (int k = 0; k < N_CH; k++) begin
         if (bus.clr_i) begin
            rcnt_d[k*CNT_W +: CNT_W] = '0;
            fcnt_d[k*CNT_W +: CNT_W] = '0;
         end else begin
            if (rise_d[k] && !(&rcnt_q[k*CNT_W +: CNT_W])) begin
               rcnt_d[k*CNT_W +: CNT_W] = rcnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (fall_d[k] && !(&fcnt_q[k*CNT_W +: CNT_W])) begin
               fcnt_d[k*CNT_W +: CNT_W] = fcnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rcnt_q <= '0;
         fcnt_q <= '0;
      end else begin
         rcnt_q <= rcnt_d;
         fcnt_q <= fcnt_d;
      end
   end

   assign bus.rise_cnt_o = rcnt_q;
   assign bus.fall_cnt_o = fcnt_q;
`else
   logic unused_clr;
   assign unused_clr     = bus.clr_i;
   assign bus.rise_cnt_o = '0;
   assign bus.fall_cnt_o = '0;
`endif

endmodule

// File: doc/edge_detector_hyst_rnm.md
EDGE_DETECTOR_HYST_RNM -- requirements
Module: edge_detector_hyst_rnm

Interface
REQ-001 Parameter N_CH, default 4: number of independent channels, 1..16.
REQ-002 Parameter VTH_HI, real, default 0.7: rising threshold.
REQ-003 Parameter VTH_LO, real, default 0.3: falling threshold, strictly below VTH_HI.
REQ-004 Parameter DEB_CYC, default 2: debounce length in clk cycles, 0..255.
REQ-005 Parameter CNT_W, default 8: edge counter width per channel, 1..32.
REQ-006 clk  input  1  single clock; all state updates on posedge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 a_i  input  real[N_CH] (wreal)  analog level per channel.
REQ-009 ch_en_i  input  N_CH  per-channel enable.
REQ-010 clr_i  input  1  synchronous clear of all edge counters.
REQ-011 level_o  output  N_CH  qualified digital level per channel.
REQ-012 rising_edge_o  output  N_CH  one-cycle pulse per qualified rising transition.
REQ-013 falling_edge_o  output  N_CH  one-cycle pulse per qualified falling transition.
REQ-014 rise_cnt_o  output  N_CH*CNT_W  packed rising-edge counts, channel k at [k*CNT_W +: CNT_W].
REQ-015 fall_cnt_o  output  N_CH*CNT_W  packed falling-edge counts, same packing.

Function
REQ-016 Candidate level per channel SHALL be: 1 if level_o=0 and a_i>=VTH_HI; 0 if level_o=1 and a_i<=VTH_LO; otherwise the current level_o.
REQ-017 Each channel SHALL hold a debounce counter; on posedge, when candidate equals level_o, counter SHALL clear to 0.
REQ-018 When candidate differs from level_o and counter<DEB_CYC, counter SHALL increment, level unchanged.
REQ-019 When candidate differs from level_o and counter==DEB_CYC, level_o SHALL take the candidate, counter SHALL clear, and the matching edge pulse SHALL assert in the same cycle.
REQ-020 Latency: input crossing held from sampling edge n SHALL update level_o at edge n+DEB_CYC; DEB_CYC=0 gives update at edge n.
REQ-021 A crossing that reverts before DEB_CYC+1 consecutive samples SHALL produce no level change and no pulse.
REQ-022 rising_edge_o[k] and falling_edge_o[k] SHALL never be high together; each pulse SHALL last exactly one cycle.
REQ-023 With ch_en_i[k]=0, channel k SHALL hold level_o, force its counter to 0, and emit no pulses or counts; re-enable SHALL resume from the held level.
REQ-024 Edge counters SHALL increment by 1 per pulse and saturate at 2^CNT_W-1 (no wrap).
REQ-025 clr_i=1 SHALL zero all counters at that posedge; clr_i coincident with a pulse SHALL yield count 0 (clear wins); pulses and level_o are unaffected by clr_i.
REQ-026 Channels SHALL be fully independent; simultaneous edges on several channels SHALL all be reported in the same cycle.

Reset
REQ-027 reset=1 SHALL immediately force level_o=0, all pulses=0, all counters and debounce counters=0, independent of clk.
REQ-028 Reset asserted mid-debounce SHALL discard the pending transition; after release, a_i held >=VTH_HI SHALL produce a rising edge DEB_CYC edges after the first sampling edge.

Configuration
REQ-029 Macro EDGE_DETECTOR_HYST_CNT_EN defined: edge counters and saturation logic compiled in per REQ-024/025.
REQ-030 Macro undefined: counter logic omitted; rise_cnt_o and fall_cnt_o SHALL be present and constant 0; clr_i ignored; all other behaviour identical.

Verification
REQ-031 Defaults, reset released, a_i[0]=1.0 held -> level_o[0]=1 and one rising_edge_o[0] pulse 2 edges after first sample; rise_cnt_o ch0=1.
REQ-032 a_i[1] toggles 0.0/1.0 every cycle with DEB_CYC=2 -> no pulses, level_o[1] stays 0.
REQ-033 a_i[2] from 1.0 (level 1) to 0.5 held 10 cycles -> no change (hysteresis); then 0.2 -> falling pulse 2 edges later.
REQ-034 300 qualified rising edges on ch3 with CNT_W=8 -> rise_cnt_o ch3=255; clr_i coincident with next pulse -> 0.
REQ-035 ch_en_i[0]=0 while a_i[0] crosses both thresholds -> no pulses, level held; reset asserted mid-debounce on ch1 -> all outputs 0 asynchronously.
REQ-036 Build without EDGE_DETECTOR_HYST_CNT_EN, rerun REQ-031 -> identical level/pulses, counter outputs 0.
